// File: rtl/rv_fetch_ctrl.sv
// rv_fetch_ctrl: instruction fetch/issue sequencer for the multi-cycle RV32I core.
// Owns the PC, issues one instruction-memory request per instruction, holds the
// returned word for decode/execute until completion, then advances or redirects.
// Traps and halts on an illegal instruction or a misaligned redirect target.
// Optional feature macro: RV_FETCH_TIMEOUT_EN adds a WAIT-state timeout trap.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | post-reset, nothing outstanding
// FETCH | request pulse for the word at pc
// WAIT  | waiting for the memory response
// ISSUE | instr_o valid, waiting for execute to finish
// HALT  | trapped; only reset leaves this state

module rv_fetch_ctrl #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int          TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_valid_o,
    input  logic        illegal_instr_i,
    input  logic        exec_done_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        trap_o,
    output logic [1:0]  trap_cause_o,
    output logic [31:0] trap_pc_o,
    output logic [31:0] retired_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    localparam logic [1:0] CAUSE_ILLEGAL   = 2'd1;
    localparam logic [1:0] CAUSE_MISALIGN  = 2'd2;
    localparam logic [1:0] CAUSE_TIMEOUT   = 2'd3;

    // A zero limit would make the timeout fire before the first response could land.
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("rv_fetch_ctrl: TIMEOUT_CYCLES must be at least 1");
    end

    logic [2:0]  state;
    logic [2:0]  state_d;
    logic [31:0] pc;
    logic        trap_q;
    logic        in_wait;
    logic        in_issue;
    logic        take_illegal;
    logic        take_misalign;
    logic        take_retire;
    logic        wait_timeout;

    assign in_wait       = (state == S_WAIT);
    assign in_issue      = (state == S_ISSUE);
    assign take_illegal  = in_issue && illegal_instr_i;
    assign take_retire   = in_issue && !illegal_instr_i && exec_done_i;
    assign take_misalign = take_retire && redirect_i && (redirect_pc_i[1:0] != 2'b00);

`ifdef RV_FETCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt;

    // The WAIT cycle that would bring the count to the limit without a response is the timeout.
    assign wait_timeout = in_wait && !imem_rvalid_i && (wait_cnt == CNT_LAST);

    // Count WAIT cycles without a response; cleared while the request goes out.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state == S_FETCH) begin
            wait_cnt <= '0;
        end else if (in_wait && !imem_rvalid_i) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign wait_timeout = 1'b0;
`endif

    // Next-state selection; faults in ISSUE take priority over normal completion.
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: state_d = S_WAIT;
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    state_d = S_ISSUE;
                end else if (wait_timeout) begin
                    state_d = S_HALT;
                end
            end
            S_ISSUE: begin
                if (take_illegal || take_misalign) begin
                    state_d = S_HALT;
                end else if (take_retire) begin
                    state_d = S_FETCH;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // State, PC, captured instruction, trap record and retire counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            pc           <= RESET_PC;
            instr_o      <= '0;
            instr_pc_o   <= '0;
            trap_q       <= 1'b0;
            trap_cause_o <= '0;
            trap_pc_o    <= '0;
            retired_o    <= '0;
        end else begin
            state <= state_d;
            if (in_wait && imem_rvalid_i) begin
                instr_o    <= imem_rdata_i;
                instr_pc_o <= pc;
            end
            if (wait_timeout) begin
                trap_q       <= 1'b1;
                trap_cause_o <= CAUSE_TIMEOUT;
                trap_pc_o    <= pc;
            end
            if (take_illegal) begin
                trap_q       <= 1'b1;
                trap_cause_o <= CAUSE_ILLEGAL;
                trap_pc_o    <= pc;
            end
            if (take_retire) begin
                retired_o <= retired_o + 32'd1;
                if (take_misalign) begin
                    trap_q       <= 1'b1;
                    trap_cause_o <= CAUSE_MISALIGN;
                    trap_pc_o    <= pc;
                end else begin
                    pc <= redirect_i ? redirect_pc_i : pc + 32'd4;
                end
            end
        end
    end

    assign imem_req_o    = (state == S_FETCH);
    assign imem_addr_o   = pc;
    assign instr_valid_o = in_issue;
    assign trap_o        = trap_q;

endmodule

// File: tb/tb_rv_fetch_ctrl.sv
// tb_rv_fetch_ctrl: randomized instruction stream against a transaction-level
// model of the fetch sequencer (expected pc, retire count, request spacing, traps).

module tb_rv_fetch_ctrl;

    localparam int TO_CYCLES = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_valid_o;
    logic        illegal_instr_i;
    logic        exec_done_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        trap_o;
    logic [1:0]  trap_cause_o;
    logic [31:0] trap_pc_o;
    logic [31:0] retired_o;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          last_req_cyc = -1;
    int          exp_period = 0;
    logic [31:0] exp_pc;
    logic [31:0] exp_ret;

    rv_fetch_ctrl #(
        .RESET_PC       (32'h0000_0000),
        .TIMEOUT_CYCLES (TO_CYCLES)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_o      (imem_req_o),
        .imem_addr_o     (imem_addr_o),
        .imem_rvalid_i   (imem_rvalid_i),
        .imem_rdata_i    (imem_rdata_i),
        .instr_o         (instr_o),
        .instr_pc_o      (instr_pc_o),
        .instr_valid_o   (instr_valid_o),
        .illegal_instr_i (illegal_instr_i),
        .exec_done_i     (exec_done_i),
        .redirect_i      (redirect_i),
        .redirect_pc_i   (redirect_pc_i),
        .trap_o          (trap_o),
        .trap_cause_o    (trap_cause_o),
        .trap_pc_o       (trap_pc_o),
        .retired_o       (retired_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    task automatic clear_inputs();
        imem_rvalid_i   = 1'b0;
        imem_rdata_i    = $urandom;
        illegal_instr_i = 1'b0;
        exec_done_i     = 1'b0;
        redirect_i      = 1'b0;
        redirect_pc_i   = $urandom;
    endtask

    // Apply reset for one edge, check the reset values, release; returns in the first FETCH cycle.
    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        check("rst_req",     32'(imem_req_o), 32'd0);
        check("rst_addr",    imem_addr_o, 32'h0);
        check("rst_instr",   instr_o, 32'h0);
        check("rst_ipc",     instr_pc_o, 32'h0);
        check("rst_valid",   32'(instr_valid_o), 32'd0);
        check("rst_trap",    32'(trap_o), 32'd0);
        check("rst_cause",   32'(trap_cause_o), 32'd0);
        check("rst_tpc",     trap_pc_o, 32'h0);
        check("rst_retired", retired_o, 32'h0);
        reset        = 1'b0;
        exp_pc       = 32'h0;
        exp_ret      = 32'h0;
        last_req_cyc = -1;
        tick();
    endtask

    // Hold in HALT for a few cycles with junk on the inputs; the trap record must not move.
    task automatic check_halt(input logic [1:0] cause, input logic [31:0] tpc);
        for (int i = 0; i < 5; i++) begin
            check("halt_trap",    32'(trap_o), 32'd1);
            check("halt_cause",   32'(trap_cause_o), 32'(cause));
            check("halt_tpc",     trap_pc_o, tpc);
            check("halt_quiet",   {30'd0, imem_req_o, instr_valid_o}, 32'd0);
            check("halt_retired", retired_o, exp_ret);
            imem_rvalid_i = 1'(i);
            imem_rdata_i  = $urandom;
            exec_done_i   = 1'(i);
            tick();
        end
        clear_inputs();
    endtask

    // One instruction: starts in FETCH. lat = WAIT cycles until rvalid, dly = extra ISSUE cycles.
    task automatic do_instr(input int lat, input int dly, input logic redir,
                            input logic [31:0] tgt, input logic illg, input logic [31:0] data);
        logic [1:0] cause;
        check("fetch_req",   32'(imem_req_o), 32'd1);
        check("fetch_addr",  imem_addr_o, exp_pc);
        check("fetch_valid", 32'(instr_valid_o), 32'd0);
        if (last_req_cyc >= 0) check("req_period", 32'(cyc - last_req_cyc), 32'(exp_period));
        last_req_cyc = cyc;
        exp_period   = lat + dly + 2;
        tick();
        for (int w = 1; w <= lat; w++) begin
            check("wait_quiet", {29'd0, imem_req_o, instr_valid_o, trap_o}, 32'd0);
            if (w == lat) begin
                imem_rvalid_i = 1'b1;
                imem_rdata_i  = data;
                exec_done_i   = 1'b0;
            end else begin
                imem_rvalid_i = 1'b0;
                imem_rdata_i  = $urandom;
                exec_done_i   = 1'($urandom_range(0, 1));
                redirect_i    = 1'($urandom_range(0, 1));
            end
            tick();
            clear_inputs();
        end
        for (int d = 0; d <= dly; d++) begin
            check("issue_valid", 32'(instr_valid_o), 32'd1);
            check("issue_instr", instr_o, data);
            check("issue_ipc",   instr_pc_o, exp_pc);
            check("issue_req",   32'(imem_req_o), 32'd0);
            if (d == dly) begin
                exec_done_i     = 1'b1;
                redirect_i      = redir;
                redirect_pc_i   = tgt;
                illegal_instr_i = illg;
            end else begin
                imem_rvalid_i = 1'($urandom_range(0, 1));
                imem_rdata_i  = $urandom;
            end
            tick();
            clear_inputs();
        end
        cause = 2'd0;
        if (illg) begin
            cause = 2'd1;
        end else if (redir && (tgt % 4 != 0)) begin
            cause   = 2'd2;
            exp_ret = exp_ret + 1;
        end else begin
            exp_ret = exp_ret + 1;
            exp_pc  = redir ? tgt : exp_pc + 32'd4;
        end
        check("retired", retired_o, exp_ret);
        if (cause != 2'd0) check_halt(cause, exp_pc);
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        tick();
        do_reset();

        // Sequential stream, response after one cycle, done one cycle into ISSUE.
        for (int i = 0; i < 3; i++) do_instr(1, 1, 1'b0, 32'h0, 1'b0, $urandom);
        check("retired_after_3", retired_o, 32'd3);
        do_instr(1, 0, 1'b1, 32'h0000_0040, 1'b0, $urandom);
        do_instr(1, 0, 1'b0, 32'h0, 1'b0, $urandom);
        do_instr(2, 0, 1'b1, 32'hFFFF_FFFC, 1'b0, $urandom);
        do_instr(1, 0, 1'b0, 32'h0, 1'b0, $urandom);
        check("wrap_pc", imem_addr_o, 32'h0);
        do_instr(1, 0, 1'b0, 32'h0, 1'b0, $urandom);

        // Random aligned stream.
        for (int i = 0; i < 40; i++) begin
            do_instr($urandom_range(1, 4), $urandom_range(0, 3),
                     ($urandom_range(0, 2) == 0), $urandom & 32'hFFFF_FFFC, 1'b0, $urandom);
        end

        // Illegal instruction flagged together with done.
        do_instr(1, 0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF);
        do_reset();

        // Misaligned redirect target.
        do_instr(1, 0, 1'b0, 32'h0, 1'b0, $urandom);
        do_instr(1, 0, 1'b1, 32'h0000_0042, 1'b0, $urandom);
        do_reset();

        // Reset in the middle of WAIT, then normal restart.
        do_instr(1, 0, 1'b1, 32'h0000_0100, 1'b0, $urandom);
        check("redir_addr", imem_addr_o, 32'h0000_0100);
        tick();
        tick();
        do_reset();
        do_instr(1, 0, 1'b0, 32'h0, 1'b0, $urandom);

`ifdef RV_FETCH_TIMEOUT_EN
        // Memory never answers: trap after the configured number of WAIT cycles.
        do_instr(1, 0, 1'b0, 32'h0, 1'b0, $urandom);
        check("to_req", 32'(imem_req_o), 32'd1);
        tick();
        for (int w = 1; w <= TO_CYCLES; w++) begin
            check("to_wait", {30'd0, trap_o, instr_valid_o}, 32'd0);
            tick();
        end
        check_halt(2'd3, exp_pc);
        do_reset();
        // Response on the last allowed WAIT cycle wins over the timeout.
        do_instr(TO_CYCLES, 0, 1'b0, 32'h0, 1'b0, $urandom);
        do_instr(1, 0, 1'b0, 32'h0, 1'b0, $urandom);
`else
        // Without the timeout a long wait is harmless.
        do_instr(3 * TO_CYCLES, 0, 1'b0, 32'h0, 1'b0, $urandom);
        do_instr(1, 0, 1'b0, 32'h0, 1'b0, $urandom);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
